// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory and buffers returned words in a small prefetch FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cpu_instruction,
    output logic        instruction_RDY_BSY,
    output logic [31:0] fetch_pc,
    input  logic        decoder_rdy_bsy,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];

    logic          head_valid;
    logic          pop;
    logic          push;
    logic [PW:0]   count_after;
    logic [31:0]   target_pc;
    logic [31:0]   pc_plus4;

    assign head_valid  = (count_q != '0);
    assign pop         = head_valid & decoder_rdy_bsy;
    assign push        = (state_q == S_REQ) & imem_ack & ~redirect_valid;
    assign count_after = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4    = pc_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_after;

        // The pop above still counts; the flush simply discards what remains.
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = target_pc;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = target_pc;
                end else if (count_after < DEPTH_C) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        addr_d = target_pc;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (count_after < DEPTH_C) begin
                        addr_d = pc_plus4;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            S_DROP: begin
                // Stale read completes here; restart at the latest target.
                if (imem_ack) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = redirect_valid ? target_pc : pc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req            = req_q;
    assign imem_addr           = addr_q;
    assign instruction_RDY_BSY = head_valid;
    assign cpu_instruction     = head_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign fetch_pc            = head_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;

endmodule
